// File: rtl/grid_piece_mover.sv
// Movement engine for the active 4-cell piece: bound check, collision reads, erase, rewrite.
// Define GRID_HARD_DROP_EN to build the hard-drop loop for cmd_op 11; otherwise 11 acts as soft down.
module grid_piece_mover #(
  parameter int unsigned COLS        = 12,
  parameter int unsigned ROWS        = 20,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned TICK_CYCLES = 50000000,
  parameter int unsigned TICK_W      = 26
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        piece_load,
  input  logic [4*$clog2(ROWS)-1:0]   piece_rows,
  input  logic [4*$clog2(COLS)-1:0]   piece_cols,
  input  logic [DATA_W-1:0]           piece_data,
  input  logic                        cmd_valid,
  input  logic [1:0]                  cmd_op,
  output logic                        cmd_ready,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic                        mem_we,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        resp_valid,
  output logic [1:0]                  resp_status,
  output logic                        busy,
  output logic                        active
);

  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(COLS);
  localparam logic [1:0] OP_LEFT    = 2'b00;
  localparam logic [1:0] OP_RIGHT   = 2'b01;
  localparam logic [1:0] OP_DOWN    = 2'b10;
  localparam logic [1:0] ST_MOVED   = 2'b00;
  localparam logic [1:0] ST_BLOCKED = 2'b01;
  localparam logic [1:0] ST_LANDED  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_BOUND, S_RD_ADDR, S_RD_DATA, S_ERASE, S_WRITE, S_RESP
  } state_t;

  state_t                 state, state_n;
  logic [1:0]             idx, idx_n, op_q, op_n, status_q, status_n;
  logic                   hit_q, hit_n, active_n, cell_hit;
  logic [3:0][RW-1:0]     row_q, row_n, tgt_row;
  logic [3:0][CW-1:0]     col_q, col_n, tgt_col;
  logic [DATA_W-1:0]      data_q, data_n, wdata_n;
  logic [TICK_W-1:0]      cnt, cnt_n;
  logic [ADDR_W-1:0]      addr_n;
  logic                   we_n, edge_hit, own, tick_due;
  logic                   unused_rdata;

  assign unused_rdata = ^mem_rdata[DATA_W-1:4];
  assign tick_due     = (cnt == TICK_W'(TICK_CYCLES - 1));

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
  endfunction

  // Target cells for the latched op and whether any cell would leave the playfield.
  always_comb begin
    tgt_row  = row_q;
    tgt_col  = col_q;
    edge_hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (op_q == OP_LEFT) begin
        tgt_col[i] = col_q[i] - CW'(1);
        if (col_q[i] == CW'(0)) edge_hit = 1'b1;
      end else if (op_q == OP_RIGHT) begin
        tgt_col[i] = col_q[i] + CW'(1);
        if (col_q[i] == CW'(COLS - 1)) edge_hit = 1'b1;
      end else begin
        tgt_row[i] = row_q[i] + RW'(1);
        if (row_q[i] == RW'(ROWS - 1)) edge_hit = 1'b1;
      end
    end
  end

  // A target that is one of the piece's own cells is not a collision.
  always_comb begin
    own = 1'b0;
    for (int j = 0; j < 4; j++)
      if (row_q[j] == tgt_row[idx] && col_q[j] == tgt_col[idx]) own = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      idx         <= '0;
      op_q        <= '0;
      status_q    <= '0;
      hit_q       <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      data_q      <= '0;
      cnt         <= '0;
      active      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
      cmd_ready   <= 1'b0;
      resp_valid  <= 1'b0;
      resp_status <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      op_q        <= op_n;
      status_q    <= status_n;
      hit_q       <= hit_n;
      row_q       <= row_n;
      col_q       <= col_n;
      data_q      <= data_n;
      cnt         <= cnt_n;
      active      <= active_n;
      mem_addr    <= addr_n;
      mem_wdata   <= wdata_n;
      mem_we      <= we_n;
      cmd_ready   <= (state_n == S_IDLE) && active_n && (cnt_n != TICK_W'(TICK_CYCLES - 1));
      resp_valid  <= (state_n == S_RESP);
      resp_status <= (state_n == S_RESP) ? status_n : ST_MOVED;
      busy        <= (state_n != S_IDLE);
    end
  end

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    op_n     = op_q;
    status_n = status_q;
    hit_n    = hit_q;
    row_n    = row_q;
    col_n    = col_q;
    data_n   = data_q;
    active_n = active;
    cnt_n    = tick_due ? cnt : cnt + TICK_W'(1);
    cell_hit = !own && (mem_rdata[3:0] != 4'h0);
    addr_n   = '0;
    wdata_n  = '0;
    we_n     = 1'b0;

    case (state)
      S_IDLE: begin
        // Gravity beats a pending command; a load only lands when nothing starts.
        if (active && tick_due) begin
          op_n    = OP_DOWN;
          cnt_n   = '0;
          state_n = S_BOUND;
        end else if (cmd_valid && cmd_ready) begin
          op_n    = cmd_op;
          state_n = S_BOUND;
        end else if (piece_load) begin
          row_n    = piece_rows;
          col_n    = piece_cols;
          data_n   = piece_data;
          active_n = 1'b1;
          cnt_n    = '0;
        end
      end
      S_BOUND: begin
        idx_n = '0;
        hit_n = 1'b0;
        if (edge_hit) begin
          status_n = op_q[1] ? ST_LANDED : ST_BLOCKED;
          state_n  = S_RESP;
        end else begin
          state_n = S_RD_ADDR;
        end
      end
      S_RD_ADDR: state_n = S_RD_DATA;
      S_RD_DATA: begin
        hit_n = hit_q || cell_hit;
        if (idx == 2'd3) begin
          idx_n = '0;
          if (hit_q || cell_hit) begin
            status_n = op_q[1] ? ST_LANDED : ST_BLOCKED;
            state_n  = S_RESP;
          end else begin
            state_n = S_ERASE;
          end
        end else begin
          idx_n   = idx + 2'd1;
          state_n = S_RD_ADDR;
        end
      end
      S_ERASE: begin
        idx_n   = idx + 2'd1;
        if (idx == 2'd3) state_n = S_WRITE;
      end
      S_WRITE: begin
        idx_n = idx + 2'd1;
        if (idx == 2'd3) begin
          row_n    = tgt_row;
          col_n    = tgt_col;
          status_n = ST_MOVED;
`ifdef GRID_HARD_DROP_EN
          state_n  = (op_q == 2'b11) ? S_BOUND : S_RESP;
`else
          state_n  = S_RESP;
`endif
        end
      end
      S_RESP: begin
        state_n = S_IDLE;
        if (status_q == ST_LANDED) active_n = 1'b0;
`ifdef GRID_HARD_DROP_EN
        if (op_q == 2'b11) cnt_n = '0;
`endif
      end
      default: state_n = S_IDLE;
    endcase

    // Memory port is registered: drive what the next state needs.
    case (state_n)
      S_RD_ADDR: addr_n = cell_addr(tgt_row[idx_n], tgt_col[idx_n]);
      S_ERASE: begin
        addr_n = cell_addr(row_q[idx_n], col_q[idx_n]);
        we_n   = 1'b1;
      end
      S_WRITE: begin
        addr_n  = cell_addr(tgt_row[idx_n], tgt_col[idx_n]);
        wdata_n = data_q;
        we_n    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_grid_piece_mover.sv
// Bench for grid_piece_mover: RAM model, behavioural move model feeding write/response scoreboards.
module tb_grid_piece_mover;

  localparam int COLS = 12;
  localparam int ROWS = 20;
  localparam int TICKS = 200;

  logic        clk = 1'b0;
  logic        reset, piece_load, cmd_valid;
  logic [19:0] piece_rows;
  logic [15:0] piece_cols;
  logic [7:0]  piece_data, mem_wdata, mem_rdata;
  logic [1:0]  cmd_op, resp_status;
  logic [7:0]  mem_addr;
  logic        cmd_ready, mem_we, resp_valid, busy, active;

  logic [7:0]  ram [256];
  logic [7:0]  grid [256];
  logic        clr, pre_we;
  logic [7:0]  pre_addr, pre_data;

  int          pr [4];
  int          pc [4];
  logic [7:0]  pdata;
  logic [15:0] wq [$];
  logic [1:0]  rq [$];
  int          cyc, resp_cyc, acc_cyc;
  int          checks, failures;

  always #5 clk = ~clk;

  grid_piece_mover #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(8), .DATA_W(8),
                     .TICK_CYCLES(TICKS), .TICK_W(26)) dut (
    .clk(clk), .reset(reset), .piece_load(piece_load), .piece_rows(piece_rows),
    .piece_cols(piece_cols), .piece_data(piece_data), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_ready(cmd_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .resp_valid(resp_valid), .resp_status(resp_status),
    .busy(busy), .active(active)
  );

  // Single-port grid RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (clr) for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    else if (pre_we) ram[pre_addr] <= pre_data;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [15:0] w;
    @(negedge clk);
    cyc++;
    if (mem_we === 1'b1) begin
      if (wq.size() == 0) chk("unexpected_write", 32'(mem_we), 32'd0);
      else begin
        w = wq.pop_front();
        chk("write_addr", 32'(mem_addr), 32'(w[15:8]));
        chk("write_data", 32'(mem_wdata), 32'(w[7:0]));
      end
    end
    if (resp_valid === 1'b1) begin
      resp_cyc = cyc;
      if (rq.size() == 0) chk("unexpected_resp", 32'(resp_valid), 32'd0);
      else chk("resp_status", 32'(resp_status), 32'(rq.pop_front()));
    end
  endtask

  task automatic clear_grid();
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 256; i++) grid[i] = 8'h00;
  endtask

  task automatic poke(input int addr, input logic [7:0] data);
    pre_we = 1'b1; pre_addr = 8'(addr); pre_data = data;
    step();
    pre_we = 1'b0;
    grid[addr] = data;
  endtask

  // Latch a piece in the DUT; the cells are drawn into the grid as the spawner would.
  task automatic load(input logic [19:0] rows, input logic [15:0] cols, input logic [7:0] data);
    for (int i = 0; i < 4; i++) begin
      pr[i] = int'(rows[i*5 +: 5]);
      pc[i] = int'(cols[i*4 +: 4]);
      poke(pr[i] * COLS + pc[i], data);
    end
    pdata = data;
    piece_rows = rows; piece_cols = cols; piece_data = data; piece_load = 1'b1;
    step();
    piece_load = 1'b0;
  endtask

  task automatic model_once(input logic [1:0] op, output logic [1:0] st);
    int tr [4];
    int tc [4];
    bit hit, own;
    st = 2'd0;
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tr[i] = pr[i] + ((op[1]) ? 1 : 0);
      tc[i] = pc[i] + ((op == 2'd0) ? -1 : (op == 2'd1) ? 1 : 0);
      if (op == 2'd0 && pc[i] == 0) st = 2'd1;
      if (op == 2'd1 && pc[i] == COLS - 1) st = 2'd1;
      if (op[1] && pr[i] == ROWS - 1) st = 2'd2;
    end
    if (st == 2'd0) begin
      for (int i = 0; i < 4; i++) begin
        own = 1'b0;
        for (int j = 0; j < 4; j++) if (tr[i] == pr[j] && tc[i] == pc[j]) own = 1'b1;
        if (!own && grid[tr[i] * COLS + tc[i]][3:0] != 4'h0) hit = 1'b1;
      end
      if (hit) st = op[1] ? 2'd2 : 2'd1;
    end
    if (st == 2'd0) begin
      for (int i = 0; i < 4; i++) begin
        wq.push_back({8'(pr[i] * COLS + pc[i]), 8'h00});
        grid[pr[i] * COLS + pc[i]] = 8'h00;
      end
      for (int i = 0; i < 4; i++) begin
        wq.push_back({8'(tr[i] * COLS + tc[i]), pdata});
        grid[tr[i] * COLS + tc[i]] = pdata;
        pr[i] = tr[i]; pc[i] = tc[i];
      end
    end
  endtask

  task automatic model_cmd(input logic [1:0] op);
    logic [1:0] st;
    logic [1:0] eop;
    eop = op;
`ifndef GRID_HARD_DROP_EN
    if (eop == 2'd3) eop = 2'd2;
`endif
    model_once(eop, st);
`ifdef GRID_HARD_DROP_EN
    for (int k = 0; k < ROWS && op == 2'd3 && st == 2'd0; k++) model_once(op, st);
`endif
    rq.push_back(st);
  endtask

  task automatic issue(input logic [1:0] op);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_op = op;
    while (cmd_ready !== 1'b1 && n < 400) begin step(); n++; end
    chk("cmd_accept", 32'(cmd_ready), 32'd1);
    step();
    acc_cyc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((rq.size() != 0 || wq.size() != 0) && n < budget) begin step(); n++; end
    chk("drain_pending", 32'(rq.size() + wq.size()), 32'd0);
    step();
  endtask

  initial begin
    int n;
    checks = 0; failures = 0; cyc = 0; resp_cyc = 0; acc_cyc = 0;
    reset = 1'b1; piece_load = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0;
    piece_rows = '0; piece_cols = '0; piece_data = '0;
    clr = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    for (int i = 0; i < 4; i++) begin pr[i] = 0; pc[i] = 0; end
    pdata = 8'h00;

    // Reset values
    clear_grid();
    step();
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_status", 32'(resp_status), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    reset = 1'b0;
    step();

    // I piece row 0 cols 4-7: right then back left
    clear_grid();
    load({5'd0, 5'd0, 5'd0, 5'd0}, {4'd7, 4'd6, 4'd5, 4'd4}, 8'h15);
    chk("load_active", 32'(active), 32'd1);
    model_cmd(2'd1); issue(2'd1); drain(100);
    chk("right_old_cell", 32'(ram[4]), 32'h00);
    chk("right_new_cell", 32'(ram[8]), 32'h15);
    model_cmd(2'd0); issue(2'd0); drain(100);
    chk("left_new_cell", 32'(ram[4]), 32'h15);
    chk("left_old_cell", 32'(ram[8]), 32'h00);

    // Left wall block
    clear_grid();
    load({5'd0, 5'd0, 5'd0, 5'd0}, {4'd3, 4'd2, 4'd1, 4'd0}, 8'h21);
    model_cmd(2'd0); issue(2'd0); drain(100);
    chk("blocked_latency_ok", 32'((resp_cyc - acc_cyc) <= 3), 32'd1);
    chk("blocked_still_active", 32'(active), 32'd1);

    // O piece on floor lands
    clear_grid();
    load({5'd19, 5'd19, 5'd18, 5'd18}, {4'd6, 4'd5, 4'd6, 4'd5}, 8'h22);
    model_cmd(2'd2); issue(2'd2); drain(100);
    chk("floor_active", 32'(active), 32'd0);
    chk("floor_cmd_ready", 32'(cmd_ready), 32'd0);
    for (int i = 0; i < 20; i++) step();
    chk("floor_cmd_ready_later", 32'(cmd_ready), 32'd0);

    // Vertical I above obstacle at (5,6)
    clear_grid();
    poke(5 * COLS + 6, 8'h33);
    load({5'd4, 5'd3, 5'd2, 5'd1}, {4'd6, 4'd6, 4'd6, 4'd6}, 8'h44);
    model_cmd(2'd2); issue(2'd2); drain(100);
    chk("obstacle_active", 32'(active), 32'd0);
    chk("obstacle_kept", 32'(ram[5 * COLS + 6]), 32'h33);
    chk("obstacle_piece_kept", 32'(ram[4 * COLS + 6]), 32'h44);

    // Gravity tick wins over a coinciding command
    clear_grid();
    load({5'd0, 5'd0, 5'd0, 5'd0}, {4'd7, 4'd6, 4'd5, 4'd4}, 8'h55);
    chk("tick_ready_before", 32'(cmd_ready), 32'd1);
    n = 0;
    while (cmd_ready === 1'b1 && n < 400) begin step(); n++; end
    chk("tick_ready_drop", 32'(cmd_ready), 32'd0);
    model_cmd(2'd2);
    model_cmd(2'd1);
    cmd_valid = 1'b1; cmd_op = 2'd1;
    step();
    chk("tick_busy", 32'(busy), 32'd1);
    issue(2'd1); drain(100);
    chk("tick_then_right", 32'(ram[1 * COLS + 8]), 32'h55);

    // Hard drop (soft down when the loop is not built)
    clear_grid();
    load({5'd0, 5'd0, 5'd0, 5'd0}, {4'd7, 4'd6, 4'd5, 4'd4}, 8'h66);
    model_cmd(2'd3); issue(2'd3); drain(2000);
    chk("drop_top_cleared", 32'(ram[4]), 32'h00);
`ifdef GRID_HARD_DROP_EN
    chk("drop_bottom_cell", 32'(ram[19 * COLS + 4]), 32'h66);
    chk("drop_active", 32'(active), 32'd0);
`else
    chk("drop_soft_cell", 32'(ram[1 * COLS + 4]), 32'h66);
    chk("drop_soft_active", 32'(active), 32'd1);
`endif

    // Reset during ERASE
    clear_grid();
    load({5'd5, 5'd5, 5'd5, 5'd5}, {4'd7, 4'd6, 4'd5, 4'd4}, 8'h77);
    model_cmd(2'd1); issue(2'd1);
    n = 0;
    while (mem_we !== 1'b1 && n < 50) begin step(); n++; end
    chk("erase_seen", 32'(mem_we), 32'd1);
    reset = 1'b1;
    step();
    chk("abort_mem_we", 32'(mem_we), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_active", 32'(active), 32'd0);
    reset = 1'b0;
    wq.delete(); rq.delete();
    step();
    chk("abort_first_erase", 32'(ram[5 * COLS + 4]), 32'h00);
    chk("abort_second_kept", 32'(ram[5 * COLS + 5]), 32'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
